poly_add_sub_ctrl: RTL and testbench

Sequencer that computes a full polynomial addition or subtraction, R[k] = (A[k] +/- B[k]) mod Q, for k = 0..N-1.
- Issues shared read addresses to the A and B coefficient memories (1-cycle read latency).
- Feeds the returned pairs through one mod_uni_add_sub instance.
- Registers each result and drives the result-memory write port.
- Sits under the poly-arith top-level scheduler and is started and monitored by start/done.

---
 rtl/poly_arith_pkg.sv | 10 +
 rtl/poly_add_sub_ctrl_if.sv | 23 ++
 rtl/mod_uni_add_sub.sv | 37 +++
 rtl/poly_add_sub_ctrl.sv | 128 ++++++++++++
 tb/tb_poly_add_sub_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the polynomial arithmetic datapath.
package poly_arith_pkg;

   localparam logic [11:0] Q      = 12'd3329;
   localparam int          POLY_N = 256;

   typedef logic [11:0] coeff_t;
   typedef logic [7:0]  poly_addr_t;

endpackage

// File: rtl/poly_add_sub_ctrl_if.sv
// Coefficient memory bus: shared A/B read port plus the result write port.
interface poly_add_sub_ctrl_if;
   import poly_arith_pkg::*;

   logic       rd_en;
   poly_addr_t rd_addr;
   coeff_t     a_rdata;
   coeff_t     b_rdata;
   logic       wr_en;
   poly_addr_t wr_addr;
   coeff_t     wr_data;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  a_rdata, b_rdata
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output a_rdata, b_rdata
   );

endinterface

// File: rtl/mod_uni_add_sub.sv
// Combinational modular add/subtract of two coefficients already reduced mod Q.
module mod_uni_add_sub
   import poly_arith_pkg::*;
(
   input  coeff_t i_op1,
   input  coeff_t i_op2,
   input  logic   i_is_sub,
   output coeff_t o_res
);

   logic [12:0] w_sum;
   logic [12:0] w_sum_red;
   logic [12:0] w_diff;
   logic [11:0] w_diff_wrap;

   always_comb begin
      w_sum       = {1'b0, i_op1} + {1'b0, i_op2};
      w_sum_red   = w_sum - {1'b0, Q};
      w_diff      = {1'b0, i_op1} - {1'b0, i_op2};
      // A negative difference lands in 1..Q-1 after adding Q, so 12 bits suffice.
      w_diff_wrap = w_diff[11:0] + Q;
      if (i_is_sub) begin
         if (w_diff[12]) begin
            o_res = w_diff_wrap;
         end else begin
            o_res = w_diff[11:0];
         end
      end else begin
         if (w_sum_red[12]) begin
            o_res = w_sum[11:0];
         end else begin
            o_res = w_sum_red[11:0];
         end
      end
   end

endmodule

// File: rtl/poly_add_sub_ctrl.sv
// Sequencer for R[k] = (A[k] +/- B[k]) mod Q over a whole polynomial:
// issues reads, runs a 2-stage pipeline through mod_uni_add_sub and writes results in order.
module poly_add_sub_ctrl
   import poly_arith_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_i,
   input  logic                       is_sub_i,
   input  logic                       stall_i,
   output logic                       busy_o,
   output logic                       done_o,
   poly_add_sub_ctrl_if.master        mem
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   poly_addr_t r_cnt;
   poly_addr_t w_cnt_nxt;
   logic       r_is_sub;
   logic       w_is_sub_nxt;
   logic       w_rd_en;

   logic       r_v1;
   poly_addr_t r_a1;
   logic       r_v2;
   poly_addr_t r_a2;
   coeff_t     r_d2;
   coeff_t     w_res;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_cnt    <= 8'd0;
         r_is_sub <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_is_sub <= w_is_sub_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_is_sub_nxt = r_is_sub;
      w_rd_en      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_is_sub_nxt = is_sub_i;
               w_cnt_nxt    = 8'd0;
               w_state_nxt  = S_RUN;
            end else begin
               w_state_nxt  = S_IDLE;
            end
         end
         S_RUN: begin
            if (!stall_i) begin
               w_rd_en   = 1'b1;
               w_cnt_nxt = r_cnt + 8'd1;
               if (r_cnt == poly_addr_t'(POLY_N - 1)) begin
                  w_state_nxt = S_DRAIN;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DRAIN: begin
            if (!r_v1 && !r_v2) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   mod_uni_add_sub u_mod_uni_add_sub (
      .i_op1    (mem.a_rdata),
      .i_op2    (mem.b_rdata),
      .i_is_sub (r_is_sub),
      .o_res    (w_res)
   );

   // Pipeline runs regardless of stall so in-flight reads always get written.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_v1 <= 1'b0;
         r_a1 <= 8'd0;
         r_v2 <= 1'b0;
         r_a2 <= 8'd0;
         r_d2 <= 12'd0;
      end else begin
         r_v1 <= w_rd_en;
         r_a1 <= r_cnt;
         r_v2 <= r_v1;
         r_a2 <= r_a1;
         if (r_v1) begin
            r_d2 <= w_res;
         end
      end
   end

   assign mem.rd_en   = w_rd_en;
   assign mem.rd_addr = r_cnt;
   assign mem.wr_en   = r_v2;
   assign mem.wr_addr = r_a2;
   assign mem.wr_data = r_d2;
   assign busy_o      = (r_state != S_IDLE);
   assign done_o      = (r_state == S_DONE);

endmodule

// File: tb/tb_poly_add_sub_ctrl.sv
// Scoreboard bench for poly_add_sub_ctrl with behavioural A/B memories.
module tb_poly_add_sub_ctrl;
   import poly_arith_pkg::*;

   typedef struct packed {
      logic [7:0]  addr;
      logic [11:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic is_sub;
   logic stall;
   logic busy;
   logic done;

   poly_add_sub_ctrl_if bus();

   poly_add_sub_ctrl dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .start_i  (start),
      .is_sub_i (is_sub),
      .stall_i  (stall),
      .busy_o   (busy),
      .done_o   (done),
      .mem      (bus)
   );

   always #5 clk = ~clk;

   logic [11:0] mem_a [POLY_N];
   logic [11:0] mem_b [POLY_N];
   logic [11:0] res   [POLY_N];
   exp_t        sb [$];

   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.a_rdata <= mem_a[bus.rd_addr];
         bus.b_rdata <= mem_b[bus.rd_addr];
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc_no, acc, wr_cnt, done_cnt, first_wr, done_at, last_rd;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int ref_op(input int a, input int b, input logic op);
      if (op) return (a - b + 3329) % 3329;
      else    return (a + b) % 3329;
   endfunction

   // Observe one cycle's outputs: scoreboard pop on writes, event bookkeeping.
   task automatic monitor();
      exp_t e;
      if (bus.wr_en) begin
         if (sb.size() == 0) begin
            chk("sb_empty_at_write", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", int'(bus.wr_addr), int'(e.addr));
            chk("wr_data", int'(bus.wr_data), int'(e.data));
         end
         res[bus.wr_addr] = bus.wr_data;
         wr_cnt++;
         if (first_wr < 0) first_wr = cyc_no;
      end
      if (bus.rd_en && bus.rd_addr == 8'd255) last_rd = cyc_no;
      if (done) begin
         done_cnt++;
         if (done_at < 0) done_at = cyc_no;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},    int'(busy), 0);
      chk({tag, "_done"},    int'(done), 0);
      chk({tag, "_rd_en"},   int'(bus.rd_en), 0);
      chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
      chk({tag, "_wr_en"},   int'(bus.wr_en), 0);
      chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
      chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
   endtask

   // stall_mode: 0 none, 1 random, 2 random then held high after the last read.
   task automatic run(input logic op, input int stall_mode, input bit pulse,
                      input int abort_at, input int exp_acc, input bit b2b);
      int wr_at_abort;
      for (int k = 0; k < POLY_N; k++) begin
         sb.push_back('{addr: 8'(k), data: 12'(ref_op(int'(mem_a[k]), int'(mem_b[k]), op))});
         res[k] = 12'hFFF;
      end
      cyc_no = 0; acc = -1; wr_cnt = 0; done_cnt = 0;
      first_wr = -1; done_at = -1; last_rd = -1;
      start = 1'b1; is_sub = op; stall = 1'b0;
      while (done_cnt == 0 && cyc_no < 3000) begin
         @(negedge clk);
         cyc_no++;
         start  = (acc < 0) ? 1'b1 : (pulse && (cyc_no == 10 || cyc_no == 100));
         is_sub = (acc >= 0 && pulse) ? 1'b1 : op;
         case (stall_mode)
            1:       stall = 1'($urandom_range(0, 1));
            2:       stall = (last_rd >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
            default: stall = 1'b0;
         endcase
         if (abort_at > 0 && cyc_no == abort_at) begin
            rst_n = 1'b0;
            start = 1'b0;
            #1;
            check_all_zero("abort");
            wr_at_abort = wr_cnt;
            repeat (3) begin
               @(negedge clk);
               #1;
               monitor();
            end
            chk("abort_no_writes", wr_cnt, wr_at_abort);
            chk("abort_no_done", done_cnt, 0);
            sb.delete();
            @(negedge clk);
            rst_n = 1'b1;
            stall = 1'b0;
            #1;
            return;
         end
         #1;
         if (acc < 0 && busy) acc = cyc_no;
         monitor();
      end
      start = 1'b0;
      stall = 1'b0;
      chk("accept_lat", acc, exp_acc);
      chk("done_cnt", done_cnt, 1);
      chk("wr_cnt", wr_cnt, POLY_N);
      chk("sb_left", sb.size(), 0);
      chk("drain_to_done", done_at - last_rd, 4);
      chk("busy_at_done", int'(busy), 1);
      if (stall_mode == 0) begin
         chk("first_wr_lat", first_wr - acc, 2);
         chk("done_lat", done_at - acc, POLY_N + 3);
      end
      sb.delete();
      if (!b2b) begin
         @(negedge clk);
         #1;
         monitor();
         chk("done_single_pulse", done_cnt, 1);
         chk("idle_after_done", int'(busy), 0);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; is_sub = 1'b0; stall = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Add, A[k]=k, B[k]=Q-1.
      for (int k = 0; k < POLY_N; k++) begin mem_a[k] = 12'(k); mem_b[k] = 12'd3328; end
      run(1'b0, 0, 1'b0, 0, 1, 1'b0);
      chk("add_r0", int'(res[0]), 3328);
      chk("add_r1", int'(res[1]), 0);
      chk("add_r255", int'(res[255]), 254);
      chk("first_wr_cycle", first_wr, 3);
      chk("done_cycle", done_at, 260);

      // Sub 0-1 and x-x.
      for (int k = 0; k < POLY_N; k++) begin mem_a[k] = 12'd0; mem_b[k] = 12'd1; end
      run(1'b1, 0, 1'b0, 0, 1, 1'b0);
      chk("sub_0m1_r17", int'(res[17]), 3328);
      for (int k = 0; k < POLY_N; k++) begin mem_a[k] = 12'd1234; mem_b[k] = 12'd1234; end
      run(1'b1, 0, 1'b0, 0, 1, 1'b0);
      chk("sub_eq_r200", int'(res[200]), 0);

      // Stall stress.
      for (int k = 0; k < POLY_N; k++) begin mem_a[k] = 12'd1664; mem_b[k] = 12'd1664; end
      run(1'b0, 1, 1'b0, 0, 1, 1'b0);
      chk("stall_r100", int'(res[100]), 3328);
      for (int k = 0; k < POLY_N; k++) begin
         mem_a[k] = 12'($urandom_range(0, 3328)); mem_b[k] = 12'($urandom_range(0, 3328));
      end
      run(1'b1, 2, 1'b0, 0, 1, 1'b0);

      // Start pulses while busy, then a start on the cycle after done.
      run(1'b0, 0, 1'b1, 0, 1, 1'b1);
      run(1'b1, 0, 1'b0, 0, 2, 1'b0);

      // Reset mid-run, then a full run.
      run(1'b0, 0, 1'b0, 50, 1, 1'b0);
      run(1'b0, 0, 1'b0, 0, 1, 1'b0);

      // Boundary operands at addresses 0 and 255.
      mem_a[0] = 12'd3328; mem_b[0] = 12'd3328; mem_a[255] = 12'd3328; mem_b[255] = 12'd3328;
      run(1'b0, 0, 1'b0, 0, 1, 1'b0);
      chk("bnd_add_r0", int'(res[0]), 3327);
      chk("bnd_add_r255", int'(res[255]), 3327);
      mem_a[0] = 12'd0; mem_b[0] = 12'd3328; mem_a[255] = 12'd3328; mem_b[255] = 12'd0;
      run(1'b1, 0, 1'b0, 0, 1, 1'b0);
      chk("bnd_sub_r0", int'(res[0]), 1);
      chk("bnd_sub_r255", int'(res[255]), 3328);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
